// File: rtl/vga_timing_pkg.sv
// Shared types, default 640x480@60 timing and the sync-level helper for the VGA timing generator.
package vga_timing_pkg;

    typedef enum logic [1:0] {PH_ACTIVE, PH_FP, PH_SYNC, PH_BP} phase_e;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Maps "sync pulse is active" to the pin level for the chosen polarity.
    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One timing axis: position counter plus ACTIVE/FP/SYNC/BP phase FSM, stepped by i_step.
// o_wrap is combinational and marks the last position of the axis.
module vga_axis_cnt
    import vga_timing_pkg::*;
#(
    parameter int P_ACTIVE = DEF_H_ACTIVE,
    parameter int P_FP     = DEF_H_FP,
    parameter int P_SYNC   = DEF_H_SYNC,
    parameter int P_BP     = DEF_H_BP,
    parameter int W        = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_step,
    output logic [W-1:0] o_cnt,
    output logic [1:0]   o_phase,
    output logic         o_wrap
);

    localparam int           TOTAL = P_ACTIVE + P_FP + P_SYNC + P_BP;
    localparam logic [W-1:0] LAST  = W'(TOTAL - 1);

    logic [W-1:0] cnt;
    logic [W-1:0] loc;
    logic [W-1:0] loc_last;
    phase_e       phase;

    always_comb begin
        loc_last = '0;
        case (phase)
            PH_ACTIVE: loc_last = W'(P_ACTIVE - 1);
            PH_FP:     loc_last = W'(P_FP - 1);
            PH_SYNC:   loc_last = W'(P_SYNC - 1);
            PH_BP:     loc_last = W'(P_BP - 1);
            default:   loc_last = '0;
        endcase
    end

    assign o_wrap  = (cnt == LAST);
    assign o_cnt   = cnt;
    assign o_phase = phase;

    // Phase boundaries line up with the position counter because the phase lengths sum to TOTAL.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            loc   <= '0;
            phase <= PH_ACTIVE;
        end else if (i_step) begin
            cnt <= o_wrap ? '0 : cnt + 1'b1;
            if (loc == loc_last) begin
                loc   <= '0;
                phase <= phase_e'(phase + 2'd1);
            end else begin
                loc <= loc + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA pixel-timing generator: registered sync/de/x/y, one pixel per tick of i_pix.
// VGA_TIMING_EDGE_DET_EN: i_pix is a level clock and ticks on its rising edge; otherwise a 1-clk enable.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int P_H_ACTIVE = DEF_H_ACTIVE,
    parameter int P_H_FP     = DEF_H_FP,
    parameter int P_H_SYNC   = DEF_H_SYNC,
    parameter int P_H_BP     = DEF_H_BP,
    parameter int P_V_ACTIVE = DEF_V_ACTIVE,
    parameter int P_V_FP     = DEF_V_FP,
    parameter int P_V_SYNC   = DEF_V_SYNC,
    parameter int P_V_BP     = DEF_V_BP,
    parameter bit P_SYNC_POL = 1'b0,
    localparam int H_TOTAL   = P_H_ACTIVE + P_H_FP + P_H_SYNC + P_H_BP,
    localparam int V_TOTAL   = P_V_ACTIVE + P_V_FP + P_V_SYNC + P_V_BP,
    localparam int HW        = $clog2(H_TOTAL),
    localparam int VW        = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_pix,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_de,
    output logic [HW-1:0] o_x,
    output logic [VW-1:0] o_y,
    output logic          o_pix_stb,
    output logic          o_frame_start
);

    if (P_H_ACTIVE == 0 || P_H_FP == 0 || P_H_SYNC == 0 || P_H_BP == 0 ||
        P_V_ACTIVE == 0 || P_V_FP == 0 || P_V_SYNC == 0 || P_V_BP == 0) begin : g_param_err
        $error("vga_timing_gen: every timing parameter must be non-zero");
    end

    logic tick;

`ifdef VGA_TIMING_EDGE_DET_EN
    logic pix_q;

    // pix_q resets high so a divider output already high at reset release is not a rising edge.
    always_ff @(posedge clk) begin
        if (!rst_n) pix_q <= 1'b1;
        else        pix_q <= i_pix;
    end

    assign tick = i_pix & ~pix_q;
`else
    assign tick = i_pix;
`endif

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [1:0]    h_phase;
    logic [1:0]    v_phase;
    logic          h_wrap;
    logic          v_wrap;

    vga_axis_cnt #(
        .P_ACTIVE(P_H_ACTIVE), .P_FP(P_H_FP), .P_SYNC(P_H_SYNC), .P_BP(P_H_BP), .W(HW)
    ) u_h (
        .clk(clk), .rst_n(rst_n), .i_step(tick),
        .o_cnt(h_cnt), .o_phase(h_phase), .o_wrap(h_wrap)
    );

    vga_axis_cnt #(
        .P_ACTIVE(P_V_ACTIVE), .P_FP(P_V_FP), .P_SYNC(P_V_SYNC), .P_BP(P_V_BP), .W(VW)
    ) u_v (
        .clk(clk), .rst_n(rst_n), .i_step(tick & h_wrap),
        .o_cnt(v_cnt), .o_phase(v_phase), .o_wrap(v_wrap)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_hsync       <= ~P_SYNC_POL;
            o_vsync       <= ~P_SYNC_POL;
            o_de          <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_pix_stb     <= 1'b0;
            o_frame_start <= 1'b0;
        end else begin
            o_pix_stb     <= tick;
            o_frame_start <= tick && (h_cnt == '0) && (v_cnt == '0);
            if (tick) begin
                o_x     <= h_cnt;
                o_y     <= v_cnt;
                o_de    <= (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
                o_hsync <= sync_level(h_phase == PH_SYNC, P_SYNC_POL);
                o_vsync <= sync_level(v_phase == PH_SYNC, P_SYNC_POL);
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 instance plus a tiny high-polarity instance
// (16x12 total) that makes whole-frame behaviour reachable in a short run.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pix = 1'b0;

    logic       hs, vs, de, stb, fs;
    logic [9:0] x, y;
    logic       hs_s, vs_s, de_s, stb_s, fs_s;
    logic [3:0] xs, ys;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    vga_timing_gen dut (
        .clk(clk), .rst_n(rst_n), .i_pix(pix),
        .o_hsync(hs), .o_vsync(vs), .o_de(de), .o_x(x), .o_y(y),
        .o_pix_stb(stb), .o_frame_start(fs)
    );

    // H: 8+2+3+3 = 16, V: 6+1+2+3 = 12, sync active-high.
    vga_timing_gen #(
        .P_H_ACTIVE(8), .P_H_FP(2), .P_H_SYNC(3), .P_H_BP(3),
        .P_V_ACTIVE(6), .P_V_FP(1), .P_V_SYNC(2), .P_V_BP(3),
        .P_SYNC_POL(1'b1)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .i_pix(pix),
        .o_hsync(hs_s), .o_vsync(vs_s), .o_de(de_s), .o_x(xs), .o_y(ys),
        .o_pix_stb(stb_s), .o_frame_start(fs_s)
    );

    task automatic do_reset();
        rst_n = 1'b0;
        pix   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Returns #1 after the edge that registers the tick.
    task automatic do_tick();
`ifdef VGA_TIMING_EDGE_DET_EN
        @(posedge clk);
        #1;
`endif
        pix = 1'b1;
        @(posedge clk);
        #1;
        pix = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (4) @(posedge clk);
        #1;
        total++; if ({de, stb, fs} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {de, stb, fs}); end
        total++; if (x !== 10'd0 || y !== 10'd0) begin bad++; $display("FAIL reset_xy: got %0d,%0d want 0,0", x, y); end
        total++; if ({hs, vs} !== 2'b11) begin bad++; $display("FAIL reset_sync: got %b want 11", {hs, vs}); end
        total++; if ({hs_s, vs_s} !== 2'b00) begin bad++; $display("FAIL reset_sync_pol1: got %b want 00", {hs_s, vs_s}); end
        total++; if ({stb_s, fs_s, de_s, xs, ys} !== 11'd0) begin bad++; $display("FAIL reset_small: got %h want 0", {stb_s, fs_s, de_s, xs, ys}); end
    endtask

    task automatic test_line();
        int fs_cnt = 0;
        do_reset();
        for (int k = 0; k <= 800; k++) begin
            do_tick();
            if (fs) fs_cnt++;
            total++; if (stb !== 1'b1) begin bad++; $display("FAIL line_stb k=%0d: got %b want 1", k, stb); end
            total++; if (x !== 10'(k % 800) || y !== 10'(k / 800)) begin
                bad++; $display("FAIL line_xy k=%0d: got %0d,%0d want %0d,%0d", k, x, y, k % 800, k / 800);
            end
            total++; if (fs !== (k == 0)) begin bad++; $display("FAIL line_fs k=%0d: got %b want %b", k, fs, k == 0); end
        end
        total++; if (fs_cnt != 1) begin bad++; $display("FAIL line_fs_count: got %0d want 1", fs_cnt); end
        @(posedge clk);
        #1;
        total++; if (stb !== 1'b0 || fs !== 1'b0) begin bad++; $display("FAIL idle_stb: got %b%b want 00", stb, fs); end
        total++; if (x !== 10'd0 || y !== 10'd1) begin bad++; $display("FAIL idle_hold: got %0d,%0d want 0,1", x, y); end
    endtask

    task automatic test_hsync_de();
        int de_cnt = 0;
        int hs_cnt = 0;
        int hs_first = -1;
        int hs_last = -1;
        do_reset();
        for (int k = 0; k < 800; k++) begin
            do_tick();
            if (de) de_cnt++;
            if (!hs) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(x);
                hs_last = int'(x);
            end
            total++; if (de !== (k < 640)) begin bad++; $display("FAIL de k=%0d: got %b want %b", k, de, k < 640); end
            total++; if (hs !== !(k >= 656 && k < 752)) begin bad++; $display("FAIL hsync k=%0d: got %b want %b", k, hs, !(k >= 656 && k < 752)); end
            total++; if (vs !== 1'b1) begin bad++; $display("FAIL vsync_line k=%0d: got %b want 1", k, vs); end
        end
        total++; if (de_cnt != 640) begin bad++; $display("FAIL de_count: got %0d want 640", de_cnt); end
        total++; if (hs_cnt != 96) begin bad++; $display("FAIL hsync_width: got %0d want 96", hs_cnt); end
        total++; if (hs_first != 656 || hs_last != 751) begin bad++; $display("FAIL hsync_span: got %0d..%0d want 656..751", hs_first, hs_last); end
    endtask

    // Two full frames of the small instance plus one tick: 385 ticks.
    task automatic test_frame();
        int fs_idx[$];
        int vs_cnt = 0;
        int ex, ey;
        do_reset();
        for (int k = 0; k <= 384; k++) begin
            do_tick();
            ex = k % 16;
            ey = (k / 16) % 12;
            if (fs_s) fs_idx.push_back(k);
            if (vs_s && k < 192) vs_cnt++;
            total++; if (xs !== 4'(ex) || ys !== 4'(ey)) begin bad++; $display("FAIL frame_xy k=%0d: got %0d,%0d want %0d,%0d", k, xs, ys, ex, ey); end
            total++; if (vs_s !== (ey >= 7 && ey < 9)) begin bad++; $display("FAIL frame_vsync k=%0d: got %b want %b", k, vs_s, ey >= 7 && ey < 9); end
            total++; if (hs_s !== (ex >= 10 && ex < 13)) begin bad++; $display("FAIL frame_hsync k=%0d: got %b want %b", k, hs_s, ex >= 10 && ex < 13); end
            total++; if (de_s !== (ex < 8 && ey < 6)) begin bad++; $display("FAIL frame_de k=%0d: got %b want %b", k, de_s, ex < 8 && ey < 6); end
        end
        total++; if (vs_cnt != 32) begin bad++; $display("FAIL frame_vsync_len: got %0d want 32", vs_cnt); end
        total++; if (fs_idx.size() != 3) begin
            bad++; $display("FAIL frame_fs_count: got %0d want 3", fs_idx.size());
        end else if (fs_idx[1] - fs_idx[0] != 192 || fs_idx[0] != 0) begin
            bad++; $display("FAIL frame_period: got %0d (first %0d) want 192 (first 0)", fs_idx[1] - fs_idx[0], fs_idx[0]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k <= 300; k++) do_tick();
        total++; if (x !== 10'd300 || y !== 10'd0) begin bad++; $display("FAIL mid_pos: got %0d,%0d want 300,0", x, y); end
        total++; if (xs !== 4'd12 || ys !== 4'd6) begin bad++; $display("FAIL mid_pos_small: got %0d,%0d want 12,6", xs, ys); end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        total++; if ({de, stb, fs, hs, vs} !== 5'b00011 || x !== 10'd0 || y !== 10'd0) begin
            bad++; $display("FAIL mid_reset: got %b x=%0d y=%0d want 00011 x=0 y=0", {de, stb, fs, hs, vs}, x, y);
        end
        total++; if ({hs_s, vs_s} !== 2'b00 || xs !== 4'd0 || ys !== 4'd0) begin
            bad++; $display("FAIL mid_reset_small: got %b x=%0d y=%0d want 00 x=0 y=0", {hs_s, vs_s}, xs, ys);
        end
        rst_n = 1'b1;
        do_tick();
        total++; if (x !== 10'd0 || y !== 10'd0 || fs !== 1'b1 || de !== 1'b1) begin
            bad++; $display("FAIL mid_restart: got x=%0d y=%0d fs=%b de=%b want 0 0 1 1", x, y, fs, de);
        end
        total++; if (xs !== 4'd0 || ys !== 4'd0 || fs_s !== 1'b1) begin
            bad++; $display("FAIL mid_restart_small: got x=%0d y=%0d fs=%b want 0 0 1", xs, ys, fs_s);
        end
    endtask

`ifdef VGA_TIMING_EDGE_DET_EN
    task automatic test_edge_det();
        int n = 0;
        rst_n = 1'b0;
        pix   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total++; if (stb !== 1'b0 || x !== 10'd0) begin bad++; $display("FAIL edge_held_high i=%0d: got stb=%b x=%0d want 0 0", i, stb, x); end
        end
        for (int i = 0; i < 20; i++) begin
            pix = ~pix;
            @(posedge clk);
            #1;
            total++; if (stb !== (i % 2 == 1)) begin bad++; $display("FAIL edge_stb i=%0d: got %b want %b", i, stb, i % 2 == 1); end
            if (stb) begin
                total++; if (x !== 10'(n)) begin bad++; $display("FAIL edge_x i=%0d: got %0d want %0d", i, x, n); end
                n++;
            end
        end
        total++; if (n != 10) begin bad++; $display("FAIL edge_count: got %0d want 10", n); end
        pix = 1'b0;
    endtask
`else
    task automatic test_pulse();
        int n = 0;
        do_reset();
        pix = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (stb) n++;
            total++; if (stb !== 1'b1 || x !== 10'(i)) begin bad++; $display("FAIL pulse_b2b i=%0d: got stb=%b x=%0d want 1 %0d", i, stb, x, i); end
        end
        pix = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (stb) n++;
            total++; if (stb !== 1'b0 || x !== 10'd2) begin bad++; $display("FAIL pulse_idle i=%0d: got stb=%b x=%0d want 0 2", i, stb, x); end
        end
        total++; if (n != 3) begin bad++; $display("FAIL pulse_count: got %0d want 3", n); end
    endtask
`endif

    initial begin
        test_reset();
        test_line();
        test_hsync_de();
        test_frame();
        test_reset_mid();
`ifdef VGA_TIMING_EDGE_DET_EN
        test_edge_det();
`else
        test_pulse();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
